uart_frame_link: RTL and testbench

// Parametrised framed RS232 link: full-duplex 8N1 UART plus frame codec. RX hunts SOF, collects PAYLOAD_BYTES,

---
 rtl/uart_frame_link.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_frame_link.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_link.sv
// Framed RS232 link: full-duplex 8N1 UART with a SOF/payload/EOF frame codec.
// The receiver hunts for SOF, collects PAYLOAD_BYTES bytes and checks EOF before
// presenting the payload. The transmitter wraps a payload word in the same frame.
module uart_frame_link #(
  parameter int         CLK_DIV       = 434,
  parameter int         PAYLOAD_BYTES = 8,
  parameter logic [7:0] SOF_BYTE      = 8'hC0,
  parameter logic [7:0] EOF_BYTE      = 8'hCF,
  parameter int         GAP_CYCLES    = 4774
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rs232_rx,
  output logic                       rs232_tx,
  output logic [8*PAYLOAD_BYTES-1:0] rx_data,
  output logic                       rx_vld,
  output logic                       rx_err,
  input  logic                       tx_en,
  input  logic [8*PAYLOAD_BYTES-1:0] tx_data,
  output logic                       tx_busy,
  output logic                       tx_done
);

  localparam int DATA_W = 8 * PAYLOAD_BYTES;
  localparam int CW     = $clog2(CLK_DIV);
  localparam int GW     = $clog2(GAP_CYCLES + 1);
  localparam int BW     = $clog2(PAYLOAD_BYTES + 2);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PAYLOAD_BYTES - 1);
  localparam logic [BW-1:0] PAY_END   = BW'(PAYLOAD_BYTES);
  localparam logic [BW-1:0] EOF_IDX   = BW'(PAYLOAD_BYTES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_bit_t;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHKEOF} rx_frame_t;

  // ---------------------------------------------------------------- RX bits
  logic [2:0]    rx_sync;
  logic          rx_line;
  logic          rx_fall;
  rx_bit_t       rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit_idx;
  logic [7:0]    rx_shreg;
  logic [7:0]    rx_byte;
  logic          rx_byte_ok;
  logic          rx_byte_vld;

  assign rx_line = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];

  // Synchronise the asynchronous serial input; the third stage feeds edge detection.
  // NOTE: two flops before any logic looks at rs232_rx keep metastability out of the FSM;
  // the sync flops reset to 1 (line idle) so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) rx_sync <= 3'b111;
    else     rx_sync <= {rx_sync[1:0], rs232_rx};
  end

  // Byte receiver: validate start at mid-bit, then sample data and stop every CLK_DIV cycles.
  // NOTE: sequential state uses non-blocking assignments only; pulses are cleared at the
  // top of the else branch and re-asserted below, so the last assignment wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit_idx  <= '0;
      rx_shreg    <= '0;
      rx_byte     <= '0;
      rx_byte_ok  <= 1'b0;
      rx_byte_vld <= 1'b0;
    end else begin
      rx_byte_vld <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_state   <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
            rx_shreg   <= {rx_line, rx_shreg[7:1]};
            rx_bit_idx <= rx_bit_idx + 1'b1;
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt      <= '0;
            rx_byte     <= rx_shreg;
            rx_byte_ok  <= rx_line;
            rx_byte_vld <= 1'b1;
            rx_state    <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- RX frame
  rx_frame_t         fr_state;
  logic [BW-1:0]     fr_idx;
  logic [DATA_W-1:0] fr_shift;
  logic [GW-1:0]     gap_cnt;

  // Frame decoder with inter-byte gap supervision; errors discard the frame and keep rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_state <= HUNT;
      fr_idx   <= '0;
      fr_shift <= '0;
      gap_cnt  <= '0;
      rx_data  <= '0;
      rx_vld   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;

      if (fr_state == HUNT || rx_state != RX_IDLE || rx_byte_vld) gap_cnt <= '0;
      else if (gap_cnt != GAP_MAX)                                gap_cnt <= gap_cnt + 1'b1;

      if (rx_byte_vld) begin
        case (fr_state)
          HUNT: begin
            if (rx_byte_ok && rx_byte == SOF_BYTE) begin
              fr_state <= PAYLOAD;
              fr_idx   <= '0;
            end
          end
          PAYLOAD: begin
            if (!rx_byte_ok) begin
              rx_err   <= 1'b1;
              fr_state <= HUNT;
            end else begin
              fr_shift <= DATA_W'({fr_shift, rx_byte});
              if (fr_idx == PAY_LAST) fr_state <= CHKEOF;
              else                    fr_idx   <= fr_idx + 1'b1;
            end
          end
          CHKEOF: begin
            if (rx_byte_ok && rx_byte == EOF_BYTE) begin
              rx_data  <= fr_shift;
              rx_vld   <= 1'b1;
              fr_state <= HUNT;
            end else begin
              rx_err <= 1'b1;
              if (rx_byte_ok && rx_byte == SOF_BYTE) begin
                fr_state <= PAYLOAD;
                fr_idx   <= '0;
              end else begin
                fr_state <= HUNT;
              end
            end
          end
          default: fr_state <= HUNT;
        endcase
      end else if (fr_state != HUNT && gap_cnt == GAP_MAX) begin
        rx_err   <= 1'b1;
        fr_state <= HUNT;
      end
    end
  end

  // --------------------------------------------------------------------- TX
  logic [CW-1:0]     tx_cnt;
  logic [3:0]        tx_bit_idx;
  logic [BW-1:0]     tx_byte_idx;
  logic [8:0]        tx_shreg;
  logic [DATA_W-1:0] tx_buf;

  // Frame transmitter: SOF, payload MSB byte first, EOF; stop and next start abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs232_tx    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_byte_idx <= '0;
      tx_shreg    <= '1;
      tx_buf      <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_en) begin
          tx_busy     <= 1'b1;
          rs232_tx    <= 1'b0;
          tx_shreg    <= {1'b1, SOF_BYTE};
          tx_buf      <= tx_data;
          tx_cnt      <= '0;
          tx_bit_idx  <= '0;
          tx_byte_idx <= '0;
        end
      end else if (tx_cnt != BIT_LAST) begin
        tx_cnt <= tx_cnt + 1'b1;
      end else begin
        tx_cnt <= '0;
        if (tx_bit_idx == 4'd9) begin
          if (tx_byte_idx == EOF_IDX) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            rs232_tx <= 1'b1;
          end else begin
            tx_byte_idx <= tx_byte_idx + 1'b1;
            tx_bit_idx  <= '0;
            rs232_tx    <= 1'b0;
            if (tx_byte_idx < PAY_END) begin
              tx_shreg <= {1'b1, tx_buf[DATA_W-1 -: 8]};
              tx_buf   <= tx_buf << 8;
            end else begin
              tx_shreg <= {1'b1, EOF_BYTE};
            end
          end
        end else begin
          rs232_tx   <= tx_shreg[0];
          tx_shreg   <= {1'b1, tx_shreg[8:1]};
          tx_bit_idx <= tx_bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_link.sv
// Directed bench for uart_frame_link: TX framing, loopback, RX error paths,
// reset mid-frame, and payload widths 1 and 16 in loopback.
module tb_uart_frame_link;

  localparam int CLK_DIV = 16;
  localparam int GAP     = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, PAYLOAD_BYTES=8
  logic        drv_rx = 1'b1;
  logic        loop   = 1'b0;
  logic        tx_line;
  logic        rx_line;
  logic [63:0] rx_data;
  logic [63:0] tx_data = '0;
  logic        rx_vld, rx_err, tx_busy, tx_done;
  logic        tx_en = 1'b0;

  assign rx_line = loop ? tx_line : drv_rx;

  uart_frame_link #(.CLK_DIV(CLK_DIV), .PAYLOAD_BYTES(8), .SOF_BYTE(8'hC0),
                    .EOF_BYTE(8'hCF), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .rs232_rx(rx_line), .rs232_tx(tx_line),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_err(rx_err),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done));

  // PAYLOAD_BYTES=1 and 16, each looped back on itself
  wire          p1_line, p16_line;
  logic [7:0]   p1_rx_data;
  logic [7:0]   p1_tx_data = '0;
  logic [127:0] p16_rx_data;
  logic [127:0] p16_tx_data = '0;
  logic         p1_en = 1'b0, p16_en = 1'b0;
  logic         p1_vld, p1_err, p1_busy, p1_done;
  logic         p16_vld, p16_err, p16_busy, p16_done;

  uart_frame_link #(.CLK_DIV(CLK_DIV), .PAYLOAD_BYTES(1), .GAP_CYCLES(GAP)) u_p1 (
    .clk(clk), .rst(rst), .rs232_rx(p1_line), .rs232_tx(p1_line),
    .rx_data(p1_rx_data), .rx_vld(p1_vld), .rx_err(p1_err),
    .tx_en(p1_en), .tx_data(p1_tx_data), .tx_busy(p1_busy), .tx_done(p1_done));

  uart_frame_link #(.CLK_DIV(CLK_DIV), .PAYLOAD_BYTES(16), .GAP_CYCLES(GAP)) u_p16 (
    .clk(clk), .rst(rst), .rs232_rx(p16_line), .rs232_tx(p16_line),
    .rx_data(p16_rx_data), .rx_vld(p16_vld), .rx_err(p16_err),
    .tx_en(p16_en), .tx_data(p16_tx_data), .tx_busy(p16_busy), .tx_done(p16_done));

  // free-running event counters; the stimulus reads differences
  int cyc = 0, busy_cyc = 0, done_cnt = 0, vld_cnt = 0, err_cnt = 0, err_cyc = 0;
  int p1_busy_cyc = 0, p1_done_cnt = 0, p1_vld_cnt = 0, p1_err_cnt = 0;
  int p16_busy_cyc = 0, p16_done_cnt = 0, p16_vld_cnt = 0, p16_err_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (tx_busy)  busy_cyc++;
    if (tx_done)  done_cnt++;
    if (rx_vld)   vld_cnt++;
    if (rx_err) begin err_cnt++; err_cyc = cyc; end
    if (p1_busy)  p1_busy_cyc++;
    if (p1_done)  p1_done_cnt++;
    if (p1_vld)   p1_vld_cnt++;
    if (p1_err)   p1_err_cnt++;
    if (p16_busy) p16_busy_cyc++;
    if (p16_done) p16_done_cnt++;
    if (p16_vld)  p16_vld_cnt++;
    if (p16_err)  p16_err_cnt++;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one 8N1 byte on drv_rx; caller is at a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drv_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    drv_rx = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    drv_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [63:0] d);
    send_byte(8'hC0, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(d[63-8*i -: 8], 1'b1);
    send_byte(8'hCF, 1'b1);
  endtask

  // decode one byte from rs232_tx; ok drops on timeout or bad stop bit
  task automatic get_tx_byte(output logic [7:0] b, output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    b  = '0;
    while (tx_line !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) ok = 1'b0;
    repeat (CLK_DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = tx_line;
    end
    repeat (CLK_DIV) @(negedge clk);
    if (tx_line !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_timeout", tx_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_tx;
    logic [7:0]  b, exp_b;
    logic        ok;
    int          b0, d0, v0, e0, n, dt;

    // ---- reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_line", tx_line, 1'b1);
    check("rst_rx_data", rx_data, 64'h0);
    check("rst_rx_vld",  rx_vld,  1'b0);
    check("rst_rx_err",  rx_err,  1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    repeat (4) @(negedge clk);

    // ---- 1: TX frame byte order and length
    exp_tx  = 64'h0123456789ABCDEF;
    tx_data = exp_tx;
    b0 = busy_cyc; d0 = done_cnt;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    check("tx_busy_after_en", tx_busy, 1'b1);
    check("tx_start_bit", tx_line, 1'b0);
    for (int k = 0; k < 10; k++) begin
      get_tx_byte(b, ok);
      if (k == 0)      exp_b = 8'hC0;
      else if (k == 9) exp_b = 8'hCF;
      else             exp_b = exp_tx[71-8*k -: 8];
      check($sformatf("tx_byte%0d", k), {ok, b}, {1'b1, exp_b});
    end
    wait_tx_idle();
    @(negedge clk);
    check("tx_busy_len", busy_cyc - b0, 1600);
    check("tx_done_cnt", done_cnt - d0, 1);

    // ---- 2: loopback with delimiter values inside the payload
    loop = 1'b1;
    tx_data = 64'hC0CFC0CF00FF55AA;
    v0 = vld_cnt; e0 = err_cnt;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    n = 0;
    while (vld_cnt == v0 && n < 2500) begin @(negedge clk); n++; end
    wait_tx_idle();
    repeat (20) @(negedge clk);
    loop = 1'b0;
    check("loop_rx_data", rx_data, 64'hC0CFC0CF00FF55AA);
    check("loop_vld_cnt", vld_cnt - v0, 1);
    check("loop_err_cnt", err_cnt - e0, 0);

    // ---- 3: junk byte, frame with bad EOF, then a good frame
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'h33, 1'b1);
    send_byte(8'hC0, 1'b1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (5) @(negedge clk);
    check("bad_eof_err", err_cnt - e0, 1);
    check("bad_eof_vld", vld_cnt - v0, 0);
    check("bad_eof_hold", rx_data, 64'hC0CFC0CF00FF55AA);
    send_frame(64'hDEADBEEF01020304);
    repeat (5) @(negedge clk);
    check("good_after_err_vld", vld_cnt - v0, 1);
    check("good_after_err_data", rx_data, 64'hDEADBEEF01020304);

    // ---- 4: inter-byte gap timeout, then recovery
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hC0, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b1);
    b0 = cyc;
    repeat (300) @(negedge clk);
    dt = err_cyc - b0;
    check("gap_err", err_cnt - e0, 1);
    check("gap_timing", (dt >= 185 && dt <= 215), 1'b1);
    check("gap_hold", rx_data, 64'hDEADBEEF01020304);
    send_frame(64'h0011223344556677);
    repeat (5) @(negedge clk);
    check("gap_recover_vld", vld_cnt - v0, 1);
    check("gap_recover_data", rx_data, 64'h0011223344556677);

    // ---- 5: short glitch inside a frame, then a stop-bit error mid-payload
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hC0, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
    drv_rx = 1'b0;
    repeat (5) @(negedge clk);
    drv_rx = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 3; i <= 8; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    send_byte(8'hCF, 1'b1);
    repeat (5) @(negedge clk);
    check("glitch_vld", vld_cnt - v0, 1);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_data", rx_data, 64'hA1A2A3A4A5A6A7A8);
    send_byte(8'hC0, 1'b1);
    send_byte(8'hB1, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    check("stop_err", err_cnt - e0, 1);
    check("stop_err_vld", vld_cnt - v0, 1);
    check("stop_err_hold", rx_data, 64'hA1A2A3A4A5A6A7A8);

    // ---- 6a: tx_en while busy is ignored, tx_data not re-sampled
    loop = 1'b1;
    v0 = vld_cnt; b0 = busy_cyc; d0 = done_cnt;
    tx_data = 64'h13579BDF2468ACE0;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (100) @(negedge clk);
    tx_data = 64'hFFFF0000FFFF0000;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    wait_tx_idle();
    repeat (20) @(negedge clk);
    loop = 1'b0;
    check("busy_en_len", busy_cyc - b0, 1600);
    check("busy_en_done", done_cnt - d0, 1);
    check("busy_en_vld", vld_cnt - v0, 1);
    check("busy_en_data", rx_data, 64'h13579BDF2468ACE0);

    // ---- 6b: reset during the start bit of byte 4
    tx_data = 64'h0123456789ABCDEF;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    repeat (650) @(negedge clk);
    check("pre_rst_line", tx_line, 1'b0);
    check("pre_rst_busy", tx_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_line", tx_line, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    check("mid_rst_done", tx_done, 1'b0);
    check("mid_rst_rx_data", rx_data, 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- payload widths 1 and 16, looped back
    p1_tx_data  = 8'hC0;
    p16_tx_data = 128'hC0CFC0CF00FF55AA0123456789ABCDEF;
    p1_en = 1'b1; p16_en = 1'b1;
    @(negedge clk);
    p1_en = 1'b0; p16_en = 1'b0;
    n = 0;
    while ((p1_busy || p16_busy) && n < 4000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("p1_busy_len",  p1_busy_cyc,  480);
    check("p1_done_cnt",  p1_done_cnt,  1);
    check("p1_vld_cnt",   p1_vld_cnt,   1);
    check("p1_err_cnt",   p1_err_cnt,   0);
    check("p1_rx_data",   p1_rx_data,   8'hC0);
    check("p16_busy_len", p16_busy_cyc, 2880);
    check("p16_done_cnt", p16_done_cnt, 1);
    check("p16_vld_cnt",  p16_vld_cnt,  1);
    check("p16_err_cnt",  p16_err_cnt,  0);
    check("p16_rx_data",  p16_rx_data,  128'hC0CFC0CF00FF55AA0123456789ABCDEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
